tone_meter: RTL and testbench



---
 rtl/tone_pkg.sv | 12 +
 rtl/tone_meter_if.sv | 16 +
 rtl/tone_meter_sync_edge.sv | 23 ++
 rtl/tone_meter.sv | 108 ++++++++++
 tb/tb_tone_meter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone generator / tone meter family.
package tone_pkg;

    localparam int unsigned DIV_W = 26;

    typedef enum logic [1:0] {
        TM_IDLE    = 2'd0,
        TM_ARM     = 2'd1,
        TM_MEASURE = 2'd2
    } tm_state_t;

endpackage

// File: rtl/tone_meter_if.sv
// Control and result signals of the tone meter, split into master/slave views.
interface tone_meter_if #(
    parameter int unsigned DIV_W = tone_pkg::DIV_W
);
    logic             en;
    logic             sig_in;
    logic [DIV_W-1:0] div_out;
    logic             valid;
    logic             locked;
    logic             timeout;

    modport master (output en, output sig_in,
                    input div_out, input valid, input locked, input timeout);
    modport slave  (input en, input sig_in,
                    output div_out, output valid, output locked, output timeout);
endinterface

// File: rtl/tone_meter_sync_edge.sv
// Two-flop synchroniser plus history flop; flags every rising and falling edge.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sig_edge
);
    logic s1, s2, hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign sig_edge = s2 ^ hist;
endmodule

// File: rtl/tone_meter.sv
// Measures the half-period of a square wave as a tone-generator div value,
// with lock qualification and a no-edge timeout.
module tone_meter #(
    parameter int unsigned DIV_W    = tone_pkg::DIV_W,
    parameter int unsigned MAX_HALF = (2 ** 26) - 1,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_N   = 4
) (
    input logic         clk,
    input logic         rst,
    tone_meter_if.slave bus
);
    import tone_pkg::*;

    localparam int unsigned      MW     = $clog2(LOCK_N + 1);
    localparam logic [DIV_W-1:0] MAX_C  = DIV_W'(MAX_HALF);
    localparam logic [DIV_W-1:0] TOL_C  = DIV_W'(TOL);
    localparam logic [DIV_W-1:0] ONE_C  = DIV_W'(1);
    localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_N);

    tm_state_t        state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] hprev;
    logic [DIV_W-1:0] diff;
    logic [MW-1:0]    match_cnt;
    logic             have_prev;
    logic             sig_edge;
    logic             is_match;

    sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.sig_in),
        .sig_edge (sig_edge)
    );

    // Larger minus smaller keeps the distance unsigned without a wider datapath.
    always_comb begin
        diff     = (cnt >= hprev) ? (cnt - hprev) : (hprev - cnt);
        is_match = have_prev && (diff <= TOL_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= TM_IDLE;
            cnt         <= '0;
            hprev       <= '0;
            match_cnt   <= '0;
            have_prev   <= 1'b0;
            bus.div_out <= '0;
            bus.valid   <= 1'b0;
            bus.locked  <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.valid   <= 1'b0;
            bus.timeout <= 1'b0;
            if (!bus.en) begin
                state      <= TM_IDLE;
                cnt        <= '0;
                match_cnt  <= '0;
                bus.locked <= 1'b0;
            end else begin
                case (state)
                    TM_IDLE: begin
                        cnt        <= '0;
                        match_cnt  <= '0;
                        bus.locked <= 1'b0;
                        state      <= TM_ARM;
                    end
                    TM_ARM: begin
                        if (sig_edge) begin
                            cnt       <= ONE_C;
                            have_prev <= 1'b0;
                            state     <= TM_MEASURE;
                        end
                    end
                    TM_MEASURE: begin
                        // An edge on the limit cycle is still a measurement.
                        if (sig_edge) begin
                            bus.div_out <= cnt - ONE_C;
                            bus.valid   <= 1'b1;
                            cnt         <= ONE_C;
                            if (is_match) begin
                                if (match_cnt < LOCK_C)
                                    match_cnt <= match_cnt + 1'b1;
                                if (match_cnt >= LOCK_C - 1'b1)
                                    bus.locked <= 1'b1;
                            end else begin
                                match_cnt  <= '0;
                                bus.locked <= 1'b0;
                            end
                            hprev     <= cnt;
                            have_prev <= 1'b1;
                        end else if (cnt == MAX_C) begin
                            bus.timeout <= 1'b1;
                            bus.locked  <= 1'b0;
                            match_cnt   <= '0;
                            state       <= TM_ARM;
                        end else begin
                            cnt <= cnt + ONE_C;
                        end
                    end
                    default: state <= TM_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tone_meter.sv
// Self-checking bench for tone_meter: toggle schedules checked against an event-level model.
module tb_tone_meter;
    localparam int unsigned DIV_W    = 26;
    localparam int          MAX_HALF = 50;
    localparam int          TOL      = 2;
    localparam int          LOCK_N   = 4;
    localparam int          NT       = 2048;
    localparam int          VB       = DIV_W + 2;
    localparam int          LB       = DIV_W + 1;
    localparam int          TB       = DIV_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tone_meter_if #(.DIV_W(DIV_W)) bus ();

    tone_meter #(
        .DIV_W    (DIV_W),
        .MAX_HALF (MAX_HALF),
        .TOL      (TOL),
        .LOCK_N   (LOCK_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-tick word layout: {valid, locked, timeout, div_out}
    bit              tog   [NT];
    logic [DIV_W+2:0] exp_w[NT];
    logic [DIV_W+2:0] obs_w[NT];
    int              seg_len;
    int              gaps[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIV_W+2:0] sample();
        return {bus.valid, bus.locked, bus.timeout, bus.div_out};
    endfunction

    task automatic do_reset();
        bus.en     = 1'b0;
        bus.sig_in = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus.en = 1'b1;
    endtask

    // First toggle at tick lead, then one toggle after each gap.
    task automatic plan(input int lead, input int tail);
        int t;
        for (int i = 0; i < NT; i++) tog[i] = 1'b0;
        t = lead;
        tog[t] = 1'b1;
        foreach (gaps[k]) begin
            t += gaps[k];
            if (t < NT) tog[t] = 1'b1;
        end
        seg_len = (t + tail < NT) ? t + tail : NT;
    endtask

    // A toggle driven after tick i shows up at tick i+3; the first seen edge arms,
    // later ones report the tick distance since the previous edge.
    task automatic build_model(input logic [DIV_W-1:0] init_div);
        bit meas, havep, lk, v, to;
        int last, hp, run, h, d;
        logic [DIV_W-1:0] dv;
        meas = 0; havep = 0; lk = 0;
        last = 0; hp = 0; run = 0;
        dv = init_div;
        for (int i = 0; i < seg_len; i++) begin
            v = 0;
            to = 0;
            if (i >= 3 && tog[i-3]) begin
                if (!meas) begin
                    meas  = 1;
                    havep = 0;
                end else begin
                    h  = i - last;
                    dv = DIV_W'(h - 1);
                    v  = 1;
                    d  = (h > hp) ? h - hp : hp - h;
                    if (havep && d <= TOL) begin
                        run = (run + 1 > LOCK_N) ? LOCK_N : run + 1;
                        if (run == LOCK_N) lk = 1;
                    end else begin
                        run = 0;
                        lk  = 0;
                    end
                    hp    = h;
                    havep = 1;
                end
                last = i;
            end else if (meas && (i - last) == MAX_HALF) begin
                to   = 1;
                meas = 0;
                lk   = 0;
                run  = 0;
            end
            exp_w[i] = {v, lk, to, dv};
        end
    endtask

    task automatic run_segment();
        for (int i = 0; i < seg_len; i++) begin
            tick();
            obs_w[i] = sample();
            if (tog[i]) bus.sig_in = ~bus.sig_in;
        end
    endtask

    task automatic test_reset();
        logic [DIV_W+2:0] w;
        bus.en = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.sig_in = ~bus.sig_in;
            tick();
            w = sample();
            checks++;
            if (w !== '0) begin
                errors++;
                $display("FAIL reset_hold tick %0d: got %h want 0", i, w);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) bus.sig_in = ~bus.sig_in;
            else bus.sig_in = 1'b0;
            tick();
            w = sample();
            checks++;
            if (w !== '0) begin
                errors++;
                $display("FAIL idle_no_output tick %0d: got %h want 0", i, w);
            end
        end
    endtask

    task automatic test_steady();
        int nv, lockv;
        do_reset();
        gaps.delete();
        repeat (12) gaps.push_back(10);
        plan(2, 8);
        build_model('0);
        run_segment();
        nv = 0;
        lockv = -1;
        for (int i = 0; i < seg_len; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL steady tick %0d: got %h want %h", i, obs_w[i], exp_w[i]);
            end
            if (obs_w[i][VB]) nv++;
            if (obs_w[i][LB] && lockv < 0) lockv = nv;
        end
        checks++;
        if (lockv !== 5) begin
            errors++;
            $display("FAIL steady_lock_valid_index: got %0d want 5", lockv);
        end
    endtask

    task automatic test_jitter();
        int hit;
        do_reset();
        gaps = '{10, 11, 9, 10, 12, 10, 14, 10};
        plan(2, 8);
        build_model('0);
        run_segment();
        hit = 0;
        for (int i = 0; i < seg_len; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL jitter tick %0d: got %h want %h", i, obs_w[i], exp_w[i]);
            end
            if (i > 0 && obs_w[i][VB] && obs_w[i][DIV_W-1:0] == DIV_W'(13)
                && !obs_w[i][LB] && obs_w[i-1][LB]) hit++;
        end
        checks++;
        if (hit !== 1) begin
            errors++;
            $display("FAIL jitter_unlock_on_14: got %0d events want 1", hit);
        end
    endtask

    task automatic test_timeout();
        int nto, race;
        do_reset();
        gaps = '{10, 10, 10, 10, 10, 10, 80, 10, 10, 50, 10};
        plan(2, 8);
        build_model('0);
        run_segment();
        nto = 0;
        race = 0;
        for (int i = 0; i < seg_len; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL timeout tick %0d: got %h want %h", i, obs_w[i], exp_w[i]);
            end
            if (obs_w[i][TB]) nto++;
            if (obs_w[i][VB] && obs_w[i][DIV_W-1:0] == DIV_W'(MAX_HALF - 1)) race++;
        end
        checks++;
        if (nto !== 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d want 1", nto);
        end
        checks++;
        if (race !== 1) begin
            errors++;
            $display("FAIL edge_timeout_race: got %0d valids with div 49 want 1", race);
        end
    endtask

    // Interrupt a locked tone mid half-period with either en low or rst.
    task automatic test_interrupt(input bit use_rst);
        logic [DIV_W+2:0] w, want;
        logic [DIV_W-1:0] held;
        do_reset();
        gaps.delete();
        repeat (7) gaps.push_back(10);
        plan(2, 5);
        build_model('0);
        run_segment();
        for (int i = 0; i < seg_len; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL interrupt_pre rst=%0d tick %0d: got %h want %h",
                         use_rst, i, obs_w[i], exp_w[i]);
            end
        end
        held = use_rst ? '0 : DIV_W'(9);
        if (use_rst) rst = 1'b1;
        else bus.en = 1'b0;
        tick();
        w = sample();
        want = {3'b000, held};
        checks++;
        if (w !== want) begin
            errors++;
            $display("FAIL interrupt_drop rst=%0d: got %h want %h", use_rst, w, want);
        end
        rst    = 1'b0;
        bus.en = 1'b1;
        gaps = '{10, 10, 10, 10};
        plan(3, 6);
        build_model(held);
        run_segment();
        for (int i = 0; i < seg_len; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL interrupt_post rst=%0d tick %0d: got %h want %h",
                         use_rst, i, obs_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        int base;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gaps.delete();
            base = $urandom_range(1, 15);
            for (int k = 0; k < 30; k++) begin
                if ($urandom_range(0, 7) == 0) gaps.push_back($urandom_range(45, 60));
                else if ($urandom_range(0, 9) == 0) base = $urandom_range(1, 15);
                else gaps.push_back(base + $urandom_range(0, 3));
            end
            plan($urandom_range(0, 4), 60);
            build_model('0);
            run_segment();
            for (int i = 0; i < seg_len; i++) begin
                checks++;
                if (obs_w[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL random round %0d tick %0d: got %h want %h",
                             r, i, obs_w[i], exp_w[i]);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en     = 1'b0;
        bus.sig_in = 1'b0;
        test_reset();
        test_steady();
        test_jitter();
        test_timeout();
        test_interrupt(1'b0);
        test_interrupt(1'b1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
